leaf_port_demux: RTL and testbench
==================================

LEAF_PORT_DEMUX -- requirements
Module: leaf_port_demux

Interface
REQ-001 Parameter PACKET_BITS, default 49, width of the BFT packet.
REQ-002 Parameter PAYLOAD_BITS, default 32, payload width per packet.
REQ-003 Parameter NUM_LEAF_BITS, default 5, leaf-address field width.
REQ-004 Parameter NUM_PORT_BITS, default 4, port field width.
REQ-005 Parameter NUM_ADDR_BITS, default 7, addr field width, carried but unused.
REQ-006 Parameter NUM_OUT_PORTS, default 4, number of user input streams.
REQ-007 Parameter FIFO_DEPTH, default 8, entries per port FIFO, power of two, at least 2.
REQ-008 Parameter LEAF_ID, default 0, this leaf's address.
REQ-009 clk  input  1  single clock for the block; all logic on its rising edge.
REQ-010 reset_n  input  1  reset, asynchronous, active-low.
REQ-011 din_leaf_bft2interface  input  PACKET_BITS  packet from BFT, no backpressure.
REQ-012 dout_leaf_interface2user  output  NUM_OUT_PORTS*PAYLOAD_BITS  per-port head payload; port k at slice k.
REQ-013 vld_interface2user  output  NUM_OUT_PORTS  port k head valid.
REQ-014 ack_user2interface  input  NUM_OUT_PORTS  port k pop.
REQ-015 freespace  output  NUM_OUT_PORTS*($clog2(FIFO_DEPTH)+1)  free entries per port.
REQ-016 overflow  output  NUM_OUT_PORTS  sticky per-port overflow flag.
REQ-017 drop_cnt  output  16  saturating count of dropped packets.

Function
REQ-018 Packet fields: bit 48 valid; [47:43] leaf; [42:39] port; [38:32] addr; [31:0] payload.
REQ-019 A packet is accepted when valid=1, leaf==LEAF_ID and port<NUM_OUT_PORTS; it pushes its payload into FIFO[port].
REQ-020 valid=0 packets are ignored silently.
REQ-021 Packets with valid=1 and leaf!=LEAF_ID are ignored and are not counted.
REQ-022 Packets with valid=1, leaf==LEAF_ID and port>=NUM_OUT_PORTS are dropped and increment drop_cnt.
REQ-023 Input capture is registered; a packet on cycle N has vld_interface2user high on cycle N+2 when the FIFO was empty (capture stage plus write).
REQ-024 Each FIFO is first-word-fall-through: vld_interface2user[k]=non-empty, and dout holds the head entry.
REQ-025 A pop occurs when vld[k] and ack[k] are both high on a clock edge; ack while vld is low is ignored.
REQ-026 A push to a full FIFO with no simultaneous pop is dropped, sets overflow[k], and increments drop_cnt.
REQ-027 A push to a full FIFO with a simultaneous pop is accepted; occupancy is unchanged and nothing is dropped.
REQ-028 Push and pop on an empty FIFO in the same cycle: the pop is ignored because vld is low, and the push is stored.
REQ-029 freespace[k] = FIFO_DEPTH - occupancy, registered and updated on the same edge as the pointers.
REQ-030 Read and write pointers wrap modulo FIFO_DEPTH and use an extra bit for full/empty detection.
REQ-031 drop_cnt saturates at 16'hFFFF.
REQ-032 overflow bits clear only on reset.
REQ-033 Ports operate independently; a full port never blocks the other ports.

Reset
REQ-034 When reset_n=0, asynchronously: all FIFOs empty, vld=0, dout=0, freespace=FIFO_DEPTH, overflow=0, drop_cnt=0, capture register valid=0.
REQ-035 Reset asserted mid-stream discards all buffered data; the first valid packet after release follows REQ-023 latency.

Structure
REQ-036 A shared package holds the packet field offsets and widths, and the function that extracts the leaf, port and payload fields.
REQ-037 A single sub-module, leaf_port_fifo, implements one FWFT FIFO with count, full and empty; the top generates NUM_OUT_PORTS instances of it.
REQ-038 No storage other than FIFO arrays and the single capture register.

Verification
REQ-039 Packet on cycle 0, leaf=0, port=2, payload=32'hDEADBEEF, ack held low -> vld[2]=1 at cycle 2, slice 2=DEADBEEF, freespace[2]=7.
REQ-040 9 back-to-back packets to port 0 with no ack -> freespace[0]=0, overflow[0]=1, drop_cnt=1; then 8 acks pop payloads in order.
REQ-041 Port 0 full; push and ack[0] in the same cycle -> no drop, freespace stays 0, head advances.
REQ-042 Packets with leaf=3 (ignored), port=9 (dropped), and valid=0 (ignored) -> no vld asserted; drop_cnt=1.
REQ-043 Interleaved pushes to ports 0-3 with random ack, 10k packets -> per-port order preserved, scoreboard matches, no drops.
REQ-044 reset_n pulsed low mid-burst with port 1 holding 5 entries -> vld=0 and freespace=8 immediately, overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/leaf_port_demux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leaf_port_demux_pkg : BFT packet field layout and field extraction helper
// Revision 1.0
// ---------------------------------------------------------------------------
package leaf_port_demux_pkg;

    localparam int PKT_PAYLOAD_W   = 32;
    localparam int PKT_ADDR_W      = 7;
    localparam int PKT_PORT_W      = 4;
    localparam int PKT_LEAF_W      = 5;

    localparam int PKT_PAYLOAD_LSB = 0;
    localparam int PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + PKT_PAYLOAD_W;
    localparam int PKT_PORT_LSB    = PKT_ADDR_LSB + PKT_ADDR_W;
    localparam int PKT_LEAF_LSB    = PKT_PORT_LSB + PKT_PORT_W;
    localparam int PKT_VALID_BIT   = PKT_LEAF_LSB + PKT_LEAF_W;
    localparam int PKT_W           = PKT_VALID_BIT + 1;

    typedef struct packed {
        logic                     valid;
        logic [PKT_LEAF_W-1:0]    leaf;
        logic [PKT_PORT_W-1:0]    port;
        logic [PKT_ADDR_W-1:0]    addr;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } pkt_fields_t;

    function automatic pkt_fields_t extract_fields(input logic [PKT_W-1:0] pkt);
        pkt_fields_t f;
        f.valid   = pkt[PKT_VALID_BIT];
        f.leaf    = pkt[PKT_LEAF_LSB    +: PKT_LEAF_W];
        f.port    = pkt[PKT_PORT_LSB    +: PKT_PORT_W];
        f.addr    = pkt[PKT_ADDR_LSB    +: PKT_ADDR_W];
        f.payload = pkt[PKT_PAYLOAD_LSB +: PKT_PAYLOAD_W];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_port_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leaf_port_fifo : first-word-fall-through FIFO with registered free space
// Revision 1.0
// ---------------------------------------------------------------------------
module leaf_port_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    freespace,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    freespace_q, freespace_d;
    logic [CW-1:0]    count_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic             wr_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop         = ack && !empty;
        wr_en       = push && (!full || pop);
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d     = wr_ptr_d - rd_ptr_d;
        freespace_d = CW'(DEPTH) - count_d;
        overflow_d  = overflow_q || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            freespace_q <= CW'(DEPTH);
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            freespace_q <= freespace_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign freespace = freespace_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: rtl/leaf_port_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leaf_port_demux : routes BFT packets addressed to this leaf into per-port FIFOs
// Revision 1.0
// ---------------------------------------------------------------------------
module leaf_port_demux
    import leaf_port_demux_pkg::*;
#(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_OUT_PORTS = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int LEAF_ID       = 0
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [PACKET_BITS-1:0]                        din_leaf_bft2interface,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]         dout_leaf_interface2user,
    output logic [NUM_OUT_PORTS-1:0]                      vld_interface2user,
    input  logic [NUM_OUT_PORTS-1:0]                      ack_user2interface,
    output logic [NUM_OUT_PORTS*($clog2(FIFO_DEPTH)+1)-1:0] freespace,
    output logic [NUM_OUT_PORTS-1:0]                      overflow,
    output logic [15:0]                                   drop_cnt
);

    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int PORT_CMP_W = PKT_PORT_W + 1;
    // A parameter set that disagrees with the package layout never accepts packets.
    localparam bit LAYOUT_OK  = (PACKET_BITS == PKT_W) &&
                                (PACKET_BITS == 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS);

    pkt_fields_t fields;
    logic        hit;
    logic        in_range;
    logic        unused_addr;

    logic                    cap_push_q,    cap_push_d;
    logic                    cap_drop_q,    cap_drop_d;
    logic [PKT_PORT_W-1:0]   cap_port_q,    cap_port_d;
    logic [PAYLOAD_BITS-1:0] cap_payload_q, cap_payload_d;
    logic [15:0]             drop_cnt_q,    drop_cnt_d;

    logic [NUM_OUT_PORTS-1:0] push;
    logic [NUM_OUT_PORTS-1:0] empty;
    logic [NUM_OUT_PORTS-1:0] full;
    logic [NUM_OUT_PORTS-1:0] fifo_drop;
    logic                     any_drop;

    always_comb begin
        fields        = extract_fields(PKT_W'(din_leaf_bft2interface));
        hit           = LAYOUT_OK && fields.valid && (fields.leaf == PKT_LEAF_W'(LEAF_ID));
        in_range      = ({1'b0, fields.port} < PORT_CMP_W'(NUM_OUT_PORTS));
        cap_push_d    = hit && in_range;
        cap_drop_d    = hit && !in_range;
        cap_port_d    = fields.port;
        cap_payload_d = PAYLOAD_BITS'(fields.payload);
    end

    assign unused_addr = ^fields.addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_push_q    <= 1'b0;
            cap_drop_q    <= 1'b0;
            cap_port_q    <= '0;
            cap_payload_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            cap_push_q    <= cap_push_d;
            cap_drop_q    <= cap_drop_d;
            cap_port_q    <= cap_port_d;
            cap_payload_q <= cap_payload_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_port
        assign push[k]      = cap_push_q && (cap_port_q == PKT_PORT_W'(k));
        assign fifo_drop[k] = push[k] && full[k] && !(ack_user2interface[k] && !empty[k]);
        assign vld_interface2user[k] = !empty[k];

        leaf_port_fifo #(
            .WIDTH (PAYLOAD_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[k]),
            .din       (cap_payload_q),
            .ack       (ack_user2interface[k]),
            .dout      (dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .empty     (empty[k]),
            .full      (full[k]),
            .freespace (freespace[k*CW +: CW]),
            .overflow  (overflow[k])
        );
    end

    // Only one FIFO is pushed per cycle, so at most one drop event occurs.
    always_comb begin
        any_drop   = cap_drop_q || (|fifo_drop);
        drop_cnt_d = drop_cnt_q;
        if (any_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_port_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_leaf_port_demux : directed and randomized scoreboard bench for leaf_port_demux
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_leaf_port_demux;

    localparam int NP = 4;
    localparam int PW = 32;
    localparam int FW = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [48:0]      din;
    logic [NP*PW-1:0] dout;
    logic [NP-1:0]    vld;
    logic [NP-1:0]    ack;
    logic [NP*FW-1:0] fs;
    logic [NP-1:0]    ovf;
    logic [15:0]      drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [NP][$];

    always #5 clk = ~clk;

    leaf_port_demux dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .din_leaf_bft2interface   (din),
        .dout_leaf_interface2user (dout),
        .vld_interface2user       (vld),
        .ack_user2interface       (ack),
        .freespace                (fs),
        .overflow                 (ovf),
        .drop_cnt                 (drop_cnt)
    );

    function automatic logic [48:0] mkpkt(input logic v, input logic [4:0] leaf,
                                          input logic [3:0] port, input logic [31:0] pl);
        return {v, leaf, port, 7'h15, pl};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every pop that the coming edge performs, then advance one cycle.
    task automatic tick();
        for (int k = 0; k < NP; k++) begin
            if (vld[k] === 1'b1 && ack[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    check("pop_unexpected_port", 128'(k), 128'hFF);
                end else begin
                    logic [31:0] e;
                    e = sb[k].pop_front();
                    check("pop_data", 128'(dout[k*PW +: PW]), 128'(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [4:0] leaf, input logic [3:0] port,
                        input logic [31:0] pl, input bit stored);
        din = mkpkt(v, leaf, port, pl);
        if (stored) sb[port].push_back(pl);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vld"},  128'(vld), 128'h0);
        check({tag, "_dout"}, 128'(dout), 128'h0);
        check({tag, "_fs"},   128'(fs), 128'h8888);
        check({tag, "_ovf"},  128'(ovf), 128'h0);
        check({tag, "_drop"}, 128'(drop_cnt), 128'h0);
    endtask

    initial begin
        int p;
        int n;
        int guard;
        reset_n = 1'b0;
        din     = '0;
        ack     = '0;
        @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;
        tick();

        // Single packet latency and FWFT head
        send(1'b1, 5'd0, 4'd2, 32'hDEADBEEF, 1'b1);
        tick();
        din = '0;
        check("lat_cycle1_vld2", 128'(vld[2]), 128'h0);
        tick();
        check("lat_cycle2_vld2", 128'(vld[2]), 128'h1);
        check("lat_dout2", 128'(dout[2*PW +: PW]), 128'hDEADBEEF);
        check("lat_fs2", 128'(fs[2*FW +: FW]), 128'd7);
        ack[2] = 1'b1;
        tick();
        ack = '0;
        check("lat_drained", 128'(vld), 128'h0);

        // Overflow on port 0: ninth packet dropped
        for (int i = 0; i < 9; i++) begin
            send(1'b1, 5'd0, 4'd0, 32'h100 + i, i < 8);
            tick();
        end
        din = '0;
        tick();
        tick();
        check("ovf_fs0", 128'(fs[0 +: FW]), 128'd0);
        check("ovf_flag", 128'(ovf), 128'h1);
        check("ovf_drop", 128'(drop_cnt), 128'd1);
        ack[0] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        ack = '0;
        check("ovf_empty", 128'(vld[0]), 128'h0);
        check("ovf_fs0_back", 128'(fs[0 +: FW]), 128'd8);

        // Push into a full FIFO with a simultaneous pop
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 5'd0, 4'd0, 32'h200 + i, 1'b1);
            tick();
        end
        din = '0;
        tick();
        tick();
        check("fullpop_pre_fs0", 128'(fs[0 +: FW]), 128'd0);
        send(1'b1, 5'd0, 4'd0, 32'h300, 1'b1);
        tick();
        din = '0;
        ack[0] = 1'b1;
        tick();
        ack = '0;
        check("fullpop_fs0", 128'(fs[0 +: FW]), 128'd0);
        check("fullpop_drop", 128'(drop_cnt), 128'd1);
        check("fullpop_head", 128'(dout[0 +: PW]), 128'h201);
        ack[0] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        ack = '0;
        check("fullpop_drained", 128'(vld), 128'h0);
        check("ovf_sticky", 128'(ovf), 128'h1);

        reset_n = 1'b0;
        tick();
        check_reset_state("reset2");
        reset_n = 1'b1;
        tick();

        // Foreign leaf, out-of-range port, invalid packet
        send(1'b1, 5'd3, 4'd0, 32'hAAAA0001, 1'b0);
        tick();
        send(1'b1, 5'd0, 4'd9, 32'hAAAA0002, 1'b0);
        tick();
        send(1'b0, 5'd0, 4'd1, 32'hAAAA0003, 1'b0);
        tick();
        din = '0;
        tick();
        tick();
        check("filter_vld", 128'(vld), 128'h0);
        check("filter_drop", 128'(drop_cnt), 128'd1);
        check("filter_ovf", 128'(ovf), 128'h0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 5'd0, 4'd1, 32'h500 + i, 1'b1);
            tick();
        end
        din = '0;
        tick();
        tick();
        check("burst_fs1", 128'(fs[1*FW +: FW]), 128'd3);
        check("burst_vld1", 128'(vld[1]), 128'h1);
        send(1'b1, 5'd0, 4'd1, 32'h600, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        for (int k = 0; k < NP; k++) sb[k].delete();
        din = '0;
        tick();
        reset_n = 1'b1;
        send(1'b1, 5'd0, 4'd3, 32'h0000ABCD, 1'b1);
        tick();
        din = '0;
        check("post_reset_c1", 128'(vld[3]), 128'h0);
        tick();
        check("post_reset_c2", 128'(vld[3]), 128'h1);
        check("post_reset_dout3", 128'(dout[3*PW +: PW]), 128'hABCD);
        ack[3] = 1'b1;
        tick();
        ack = '0;

        // Randomized interleaving across all ports
        n = 0;
        guard = 0;
        while (n < 10000 && guard < 60000) begin
            p = $urandom_range(0, NP - 1);
            ack = 4'($urandom);
            if (sb[p].size() < 6) begin
                send(1'b1, 5'd0, 4'(p), $urandom, 1'b1);
                n++;
            end else begin
                din = '0;
            end
            tick();
            guard++;
        end
        check("random_sent", 128'(n), 128'd10000);
        din = '0;
        ack = '1;
        guard = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && guard < 50) begin
            tick();
            guard++;
        end
        ack = '0;
        check("random_sb_empty", 128'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 128'd0);
        check("random_vld", 128'(vld), 128'h0);
        check("random_drop", 128'(drop_cnt), 128'd0);
        check("random_ovf", 128'(ovf), 128'h0);
        check("random_fs", 128'(fs), 128'h8888);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
